// File: rtl/mult_sched_if.sv
// Bundle of the requester, multiplier and result channels around mult_sched.
// The scheduler sits on the slave side; the requesters, the multiplier and the
// result consumer together form the master side.
interface mult_sched_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) ();
    // Requester side: one operand pair per requester, packed 12 bits per lane.
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*12-1:0] req_a;
    logic [N_REQ*12-1:0] req_b;

    // Shared multiplier operands and result.
    logic [11:0]         mul_in1;
    logic [11:0]         mul_in2;
    logic [11:0]         mul_res;

    // Result channel; it has no backpressure.
    logic                res_valid;
    logic [ID_W-1:0]     res_id;
    logic [11:0]         res_data;

    modport slave (
        input  req_valid,
        input  req_a,
        input  req_b,
        input  mul_res,
        output req_ready,
        output mul_in1,
        output mul_in2,
        output res_valid,
        output res_id,
        output res_data
    );

    modport master (
        output req_valid,
        output req_a,
        output req_b,
        output mul_res,
        input  req_ready,
        input  mul_in1,
        input  mul_in2,
        input  res_valid,
        input  res_id,
        input  res_data
    );
endinterface

// File: rtl/mult_sched.sv
// Round-robin scheduler that shares one fixed-latency, non-stalling modular
// multiplier between N_REQ requesters. Each issued operation is tagged with its
// requester ID in a shadow pipeline as deep as the multiplier, so every result
// leaves together with the ID of the requester that issued it.
module mult_sched #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned MULT_LATENCY = 6,
    parameter int unsigned ID_W         = 2,
    parameter int unsigned CNT_W        = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    mult_sched_if.slave      bus_io,
    output logic [CNT_W-1:0] inflight_o,
    output logic             idle_o
);
    localparam int unsigned DataW = 12;

    // Resetting the pointer to the last index gives requester 0 top priority.
    localparam logic [ID_W-1:0] PtrRst = ID_W'(N_REQ - 1);

    logic [ID_W-1:0]         last_grant_q, last_grant_d;
    logic                    grant_vld;
    logic [ID_W-1:0]         grant_id;
    logic [N_REQ-1:0]        grant_oh;
    logic [ID_W-1:0]         cand;

    logic [MULT_LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [ID_W-1:0]         tag_id_q [MULT_LATENCY];
    logic [ID_W-1:0]         tag_id_d [MULT_LATENCY];

    logic [CNT_W-1:0]        inflight_q, inflight_d;
    logic                    res_vld;

    // Round-robin scan starting one past the last grant, first valid wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        grant_oh  = '0;
        cand      = '0;
        if (en_i) begin
            for (int unsigned k = 1; k <= N_REQ; k++) begin
                cand = ID_W'((32'(last_grant_q) + k) % N_REQ);
                if (!grant_vld && bus_io.req_valid[cand]) begin
                    grant_vld      = 1'b1;
                    grant_id       = cand;
                    grant_oh[cand] = 1'b1;
                end
            end
        end
    end

    assign bus_io.req_ready = grant_oh;

    // Steer the granted lane's operands onto the multiplier, zero otherwise.
    always_comb begin
        bus_io.mul_in1 = '0;
        bus_io.mul_in2 = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_oh[i]) begin
                bus_io.mul_in1 = bus_io.req_a[i*DataW +: DataW];
                bus_io.mul_in2 = bus_io.req_b[i*DataW +: DataW];
            end
        end
    end

    // Pointer only advances on an actual grant, so en=0 resumes where it left.
    always_comb begin
        last_grant_d = last_grant_q;
        if (grant_vld) begin
            last_grant_d = grant_id;
        end
    end

    // Shadow tag pipeline shifts every cycle, matching the multiplier exactly.
    always_comb begin
        tag_vld_d    = '0;
        tag_vld_d[0] = grant_vld;
        tag_id_d[0]  = grant_vld ? grant_id : tag_id_q[0];
        for (int unsigned i = 1; i < MULT_LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
    end

    assign res_vld          = tag_vld_q[MULT_LATENCY-1];
    assign bus_io.res_valid = res_vld;
    assign bus_io.res_id    = tag_id_q[MULT_LATENCY-1];
    assign bus_io.res_data  = bus_io.mul_res;

    // In-flight count: issue and retire in the same cycle cancel out.
    always_comb begin
        inflight_d = inflight_q;
        if (grant_vld && !res_vld) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!grant_vld && res_vld) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    assign inflight_o = inflight_q;
    assign idle_o     = (inflight_q == '0) && (bus_io.req_valid == '0);

    // State registers; reset discards every tag still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= PtrRst;
            tag_vld_q    <= '0;
            inflight_q   <= '0;
            for (int unsigned i = 0; i < MULT_LATENCY; i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            last_grant_q <= last_grant_d;
            tag_vld_q    <= tag_vld_d;
            inflight_q   <= inflight_d;
            for (int unsigned i = 0; i < MULT_LATENCY; i++) begin
                tag_id_q[i] <= tag_id_d[i];
            end
        end
    end

    // Structural invariants of the scheduler.
    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_oh));
    a_inflight_max: assert property (@(posedge clk) disable iff (rst)
                                     inflight_q <= CNT_W'(MULT_LATENCY));
endmodule

// File: tb/tb_mult_sched.sv
// Directed bench for mult_sched: a cycle table for the single-op and
// streaming/drain scenarios, then hand-written wrap, enable and reset cases.
module tb_mult_sched;
    localparam int unsigned NReq = 4;
    localparam int unsigned Lat  = 6;
    localparam int unsigned IdW  = 2;
    localparam int unsigned CntW = 3;

    logic            clk;
    logic            rst;
    logic            en;
    logic [CntW-1:0] inflight;
    logic            idle;

    int n_vec;
    int n_bad;

    mult_sched_if #(.N_REQ(NReq), .ID_W(IdW)) bus ();

    mult_sched #(
        .N_REQ       (NReq),
        .MULT_LATENCY(Lat),
        .ID_W        (IdW),
        .CNT_W       (CntW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en_i      (en),
        .bus_io    (bus.slave),
        .inflight_o(inflight),
        .idle_o    (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference multiplier: fixed latency, never reset, product mod 3329.
    logic [11:0] mpipe [Lat];
    always @(posedge clk) begin
        mpipe[0] <= 12'((32'(bus.mul_in1) * 32'(bus.mul_in2)) % 3329);
        for (int i = 1; i < Lat; i++) mpipe[i] <= mpipe[i-1];
    end
    assign bus.mul_res = mpipe[Lat-1];

    typedef struct {
        logic        pre_rst;
        logic        en;
        logic [3:0]  valid;
        logic [11:0] a;
        logic [11:0] b;
        logic [3:0]  ready;
        logic [11:0] mul1;
        logic [11:0] mul2;
        logic        rvld;
        logic [1:0]  rid;
        logic [11:0] rdata;
        logic [2:0]  infl;
        logic        idle;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic set_all(input logic [3:0] v, input logic [11:0] a, input logic [11:0] b);
        bus.req_valid = v;
        for (int i = 0; i < NReq; i++) begin
            bus.req_a[i*12 +: 12] = a;
            bus.req_b[i*12 +: 12] = b;
        end
    endtask

    task automatic set_lane(input int i, input logic [11:0] a, input logic [11:0] b);
        bus.req_a[i*12 +: 12] = a;
        bus.req_b[i*12 +: 12] = b;
    endtask

    // Ends at posedge+1 with reset released, ready to drive cycle 0.
    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b1;
        set_all(4'b0000, 12'd0, 12'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string p, input logic v, input logic [1:0] id,
                           input logic [11:0] d);
        chk({p, " res_valid"}, 32'(bus.res_valid), 32'(v));
        if (v) begin
            chk({p, " res_id"}, 32'(bus.res_id), 32'(id));
            chk({p, " res_data"}, 32'(bus.res_data), 32'(d));
        end
    endtask

    function automatic vec_t mk(logic pr, logic e, logic [3:0] v, logic [11:0] a,
                                logic [11:0] b, logic [3:0] rdy, logic [11:0] m1,
                                logic [11:0] m2, logic rv, logic [1:0] rid,
                                logic [11:0] rd, logic [2:0] inf, logic idl);
        vec_t t;
        t.pre_rst = pr; t.en = e; t.valid = v; t.a = a; t.b = b;
        t.ready = rdy; t.mul1 = m1; t.mul2 = m2; t.rvld = rv; t.rid = rid;
        t.rdata = rd; t.infl = inf; t.idle = idl;
        return t;
    endfunction

    initial begin
        string p;
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b1;
        en    = 1'b0;
        set_all(4'b0000, 12'd0, 12'd0);

        // Single op from requester 2: 17*17 = 289, back after 6 cycles.
        tbl.push_back(mk(1, 1, 4'b0100, 17, 17, 4'b0100, 17, 17, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 5; k++)
            tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 4'b0000, 0, 0, 1, 2, 289, 1, 0));
        tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1));

        // All valid with 1000*1000 mod 3329 = 1300 for 10 cycles, then drain.
        for (int k = 0; k <= 16; k++) begin
            logic       v;
            logic       rv;
            logic [2:0] inf;
            v   = (k < 10);
            rv  = (k >= 6) && (k <= 15);
            inf = (k <= 6) ? 3'(k) : ((k <= 10) ? 3'd6 : 3'(16 - k));
            tbl.push_back(mk((k == 0), 1, v ? 4'b1111 : 4'b0000, 1000, 1000,
                             v ? 4'(1 << (k % 4)) : 4'b0000,
                             v ? 12'd1000 : 12'd0, v ? 12'd1000 : 12'd0,
                             rv, rv ? 2'((k - 6) % 4) : 2'd0, rv ? 12'd1300 : 12'd0,
                             inf, (k == 16)));
        end

        foreach (tbl[i]) begin
            if (tbl[i].pre_rst) begin
                chk($sformatf("v%0d reset res_valid", i), 32'(bus.res_valid), 0);
                do_reset();
                chk($sformatf("v%0d reset inflight", i), 32'(inflight), 0);
                chk($sformatf("v%0d reset res_id", i), 32'(bus.res_id), 0);
            end
            en = tbl[i].en;
            set_all(tbl[i].valid, tbl[i].a, tbl[i].b);
            #1;
            p = $sformatf("v%0d", i);
            chk({p, " ready"}, 32'(bus.req_ready), 32'(tbl[i].ready));
            chk({p, " mul_in1"}, 32'(bus.mul_in1), 32'(tbl[i].mul1));
            chk({p, " mul_in2"}, 32'(bus.mul_in2), 32'(tbl[i].mul2));
            chk_res(p, tbl[i].rvld, tbl[i].rid, tbl[i].rdata);
            chk({p, " inflight"}, 32'(inflight), 32'(tbl[i].infl));
            chk({p, " idle"}, 32'(idle), 32'(tbl[i].idle));
            next_cycle();
        end

        // Wrap-around with requesters 1 and 3: grants 1,3,1.
        do_reset();
        set_all(4'b1010, 0, 0);
        set_lane(1, 3328, 3328);
        set_lane(3, 5, 7);
        for (int c = 0; c <= 9; c++) begin
            if (c == 3) set_all(4'b0000, 0, 0);
            #1;
            p = $sformatf("wrap c%0d", c);
            if (c < 3) begin
                chk({p, " ready"}, 32'(bus.req_ready), (c == 1) ? 32'b1000 : 32'b0010);
                chk({p, " mul_in1"}, 32'(bus.mul_in1), (c == 1) ? 32'd5 : 32'd3328);
                chk({p, " mul_in2"}, 32'(bus.mul_in2), (c == 1) ? 32'd7 : 32'd3328);
            end
            if (c == 6 || c == 8) chk_res(p, 1, 1, 12'd1);
            else if (c == 7)      chk_res(p, 1, 3, 12'd35);
            else                  chk_res(p, 0, 0, 0);
            if (c == 9) begin
                chk({p, " inflight"}, 32'(inflight), 0);
                chk({p, " idle"}, 32'(idle), 1);
            end
            next_cycle();
        end

        // Enable gating: earlier op drains, requester 0 waits until en returns.
        do_reset();
        set_all(4'b0100, 2, 3);
        for (int c = 0; c <= 13; c++) begin
            if (c == 1) begin
                en = 1'b0;
                set_all(4'b0001, 9, 9);
            end
            if (c == 7) en = 1'b1;
            if (c == 8) set_all(4'b0000, 0, 0);
            #1;
            p = $sformatf("en c%0d", c);
            if (c == 0) chk({p, " ready"}, 32'(bus.req_ready), 32'b0100);
            if (c >= 1 && c <= 6) begin
                chk({p, " ready"}, 32'(bus.req_ready), 0);
                chk({p, " mul_in1"}, 32'(bus.mul_in1), 0);
                chk({p, " mul_in2"}, 32'(bus.mul_in2), 0);
            end
            if (c == 7) begin
                chk({p, " ready"}, 32'(bus.req_ready), 32'b0001);
                chk({p, " mul_in1"}, 32'(bus.mul_in1), 9);
            end
            if (c == 6)       chk_res(p, 1, 2, 12'd6);
            else if (c == 13) chk_res(p, 1, 0, 12'd81);
            else              chk_res(p, 0, 0, 0);
            next_cycle();
        end

        // Reset mid-flight discards all three tags and rewinds the pointer.
        do_reset();
        set_all(4'b0111, 4, 4);
        for (int c = 0; c <= 11; c++) begin
            p = $sformatf("rst c%0d", c);
            if (c == 3) set_all(4'b0000, 0, 0);
            if (c == 4) begin
                #1;
                chk({p, " inflight pre"}, 32'(inflight), 3);
                rst = 1'b1;
            end
            if (c == 6) rst = 1'b0;
            if (c == 11) set_all(4'b1111, 4, 4);
            #1;
            if (c < 3) chk({p, " ready"}, 32'(bus.req_ready), 32'(1 << c));
            if (c >= 4) begin
                chk({p, " res_valid"}, 32'(bus.res_valid), 0);
                chk({p, " inflight"}, 32'(inflight), 0);
            end
            if (c == 11) chk({p, " ready"}, 32'(bus.req_ready), 32'b0001);
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mult_sched.md
Name: mult_sched

Overview:
- Round-robin scheduler that shares one pipelined Kyber modular multiplier (12-bit operands, q = 3329, fixed latency, no stall) between N_REQ requesters (NTT butterfly lanes, pointwise-multiply unit, etc.).
- Accepts one operand pair per cycle via valid/ready and drives the multiplier inputs.
- Tags every issued operation with its requester ID in a shadow pipeline matched to the multiplier latency.
- Returns each result with the ID of the requester that issued it.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MULT_LATENCY, 6, cycles from the cycle operands are driven on mul_in1/mul_in2 to the cycle mul_res carries the product mod q. Must equal the latency of the instantiated multiplier; must be ≥1.
- ID_W, 2, requester ID width; clog2(N_REQ).
- CNT_W, 3, in-flight counter width; clog2(MULT_LATENCY+1).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- en  in  1  issue enable; 0 blocks new grants, in-flight operations still drain
- req_valid  in  N_REQ  per-requester operand-pair valid
- req_a  in  N_REQ*12  operand A, requester i at bits [12i+11:12i]
- req_b  in  N_REQ*12  operand B, same packing
- req_ready  out  N_REQ  one-hot grant; the handshake fires when req_valid[i] & req_ready[i]
- mul_in1  out  12  operand A to multiplier
- mul_in2  out  12  operand B to multiplier
- mul_res  in  12  multiplier result
- res_valid  out  1  result valid
- res_id  out  ID_W  requester ID owning res_data
- res_data  out  12  result (mul_res passed through)
- inflight  out  CNT_W  number of issued operations not yet returned
- idle  out  1  high when inflight == 0 and no req_valid is asserted

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk.
  - Tag pipeline valids cleared; IDs set to 0.
  - Round-robin pointer set so requester 0 has highest priority.
  - inflight = 0; res_valid = 0; res_id = 0.
- Reset asserted mid-operation: all in-flight tags are discarded. No res_valid is produced for them, even though the multiplier still emits data.
- Arbitration (combinational):
  - When en = 1, scan from (last_grant+1) mod N_REQ upward with wrap-around.
  - The first i with req_valid[i] = 1 gets req_ready[i] = 1; at most one ready bit is high.
  - When en = 0 or no valid is asserted, req_ready = 0.
  - req_ready does not depend on a requester's own valid other than through the scan.
- Issue cycle: mul_in1/mul_in2 = req_a/req_b of the granted requester, else 12'd0. On the clock edge:
  - last_grant is updated to the granted index; it is unchanged when there is no grant.
  - Tag stage 0 is loaded with {1, id}; otherwise stage 0 gets {0, hold-previous id}.
- Tag pipeline: MULT_LATENCY stages, shifting every cycle, unconditionally.
  - res_valid = stage[MULT_LATENCY-1].valid.
  - res_id = stage[MULT_LATENCY-1].id.
  - res_data = mul_res, combinational passthrough; it is don't-care when res_valid = 0.
  - A result for an operation issued in cycle t appears in cycle t+MULT_LATENCY.
- Result channel: no backpressure. Consumers must accept res_* in the cycle it is valid.
- Throughput: one issue per cycle sustained. With all requesters valid, grants cycle 0,1,2,3,0,… Each requester gets ≥1 grant per N_REQ cycles.
- inflight counter:
  - +1 on issue only; −1 on res_valid only; unchanged when both occur in the same cycle.
  - Never exceeds MULT_LATENCY and never underflows.
- Operands are not range-checked; callers supply values < 3329.
- en deassertion does not flush anything. Re-asserting en resumes round-robin from the stored last_grant.

Test Plan:
1. Reset, then requester 2 holds (17,17) for one handshake → req_ready = 4'b0100 that cycle; 6 cycles later res_valid = 1, res_id = 2, res_data = 289; inflight goes 0→1→0.
2. All four requesters valid continuously, each requester's A = B = 1000 → grant order 0,1,2,3,0,…; a result every cycle after latency with res_data = 1300 and res_id sequence 0,1,2,3,…
3. Requesters 1 and 3 valid, last_grant = 3 → next grant goes to 1, then 3, then 1 (wrap-around check); requester 1 with (3328,3328) → res_data = 1.
4. Back-to-back issue for 6 cycles → inflight saturates at 6 with simultaneous inc/dec holding it steady; drop all valids → inflight counts down to 0, then idle = 1.
5. en = 0 while requester 0 valid → req_ready = 0 and mul_in1 = mul_in2 = 0; earlier-issued results still drain; en = 1 → requester 0 granted next cycle.
6. Issue 3 operations, assert rst 2 cycles later → res_valid stays 0 for all 3, inflight = 0, pointer reset (requester 0 wins first after release).
